// File: rtl/miv_ram_ecc_pkg.sv
// Shared types and helpers for the SECDED-protected RAM with background scrubber.
// Check bits are Hamming parity over data bits placed at non-power-of-two positions, plus overall parity.
package miv_ram_ecc_pkg;

    typedef enum logic [2:0] {
        SCR_IDLE,
        SCR_WAIT,
        SCR_READ,
        SCR_CHECK,
        SCR_WBACK
    } scrub_state_e;

    typedef enum logic [1:0] {
        INJ_NONE = 2'b00,
        INJ_SB   = 2'b01,
        INJ_DB   = 2'b10,
        INJ_OFF  = 2'b11
    } inj_e;

    function automatic int secded_cw(input int width);
        int r;
        r = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << r) < width + r + 1) r = r + 1;
        end
        secded_cw = r + 1;
    endfunction

    // Hamming position of data bit idx: the idx-th integer >= 3 that is not a power of two.
    function automatic int data_pos(input int idx);
        int k;
        data_pos = 0;
        k = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k == idx) data_pos = p;
                k++;
            end
        end
    endfunction

endpackage

// File: rtl/miv_secded_codec.sv
// Combinational SECDED encoder and decoder; codeword layout is {overall parity, Hamming bits, data}.
// On a double-bit error the decoder passes the raw data bits through unchanged.
module miv_secded_codec
    import miv_ram_ecc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = secded_cw(WIDTH)
) (
    input  logic [WIDTH-1:0]    data_i,
    output logic [WIDTH+CW-1:0] cw_o,
    input  logic [WIDTH+CW-1:0] cw_i,
    output logic [WIDTH-1:0]    data_o,
    output logic                sb_o,
    output logic                db_o
);
    localparam int R = CW - 1;

    logic [R-1:0] pos [WIDTH];
    logic [R-1:0] enc_h;
    logic [R-1:0] syn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
        assign pos[i] = R'(data_pos(i));
    end

    // XOR of the positions of all set data bits is exactly the Hamming check vector.
    always_comb begin
        enc_h = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) enc_h = enc_h ^ pos[i];
        end
    end

    assign cw_o = {^{enc_h, data_i}, enc_h, data_i};

    always_comb begin
        syn = cw_i[WIDTH +: R];
        for (int i = 0; i < WIDTH; i++) begin
            if (cw_i[i]) syn = syn ^ pos[i];
        end
        sb_o   = ^cw_i;
        db_o   = ~(^cw_i) & (syn != '0);
        data_o = cw_i[WIDTH-1:0];
        if (sb_o) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (syn == pos[i]) data_o[i] = ~cw_i[i];
            end
        end
    end

endmodule

// File: rtl/miv_ram_ecc_scrub.sv
// 1R1W SECDED RAM with registered error flags, saturating error counters, error injection
// and a background scrubber that only borrows the array ports on idle cycles.
module miv_ram_ecc_scrub
    import miv_ram_ecc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 2048,
    parameter int AW             = $clog2(DEPTH),
    parameter int CW             = secded_cw(WIDTH),
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             WEN,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WD,
    input  logic             REN,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RD,
    output logic             RD_VALID,
    output logic             SB_CORRECT,
    output logic             DB_DETECT,
    input  logic             SCRUB_EN,
    input  logic [1:0]       INJ_ERR,
    output logic [CNT_W-1:0] SB_COUNT,
    output logic [CNT_W-1:0] DB_COUNT,
    output logic [AW-1:0]    ERR_ADDR,
    output logic             ERR_VALID,
    input  logic             CNT_CLR
);
    localparam int NW = WIDTH + CW;
    localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
        return (sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [NW-1:0]    mem_q [DEPTH];
    scrub_state_e     state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    icnt_q, icnt_d;
    logic [WIDTH-1:0] scr_data_q;
    logic             scr_sb_q, scr_db_q;
    logic             scr_rd, wb_fire, scr_sb_hit, scr_db_hit;
    logic [WIDTH-1:0] rd_p1_q;
    logic             vld_p1_q, sb_p1_q, db_p1_q;
    logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
    logic [AW-1:0]    err_addr_q, err_addr_d;
    logic             err_vld_q, err_vld_d;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [WIDTH-1:0] wr_data, dec_data;
    logic [NW-1:0]    wr_cw, inj_mask;
    logic             dec_sb, dec_db, usr_sb, usr_db;
    logic [WIDTH-1:0] enc_unused_data;
    logic             enc_unused_sb, enc_unused_db;
    logic [NW-1:0]    dec_unused_cw;

    assign rd_addr = REN ? RADDR : ptr_q;
    assign wr_addr = WEN ? WADDR : ptr_q;
    assign wr_data = WEN ? WD : scr_data_q;

    miv_secded_codec #(.WIDTH(WIDTH), .CW(CW)) u_enc (
        .data_i (wr_data),
        .cw_o   (wr_cw),
        .cw_i   ('0),
        .data_o (enc_unused_data),
        .sb_o   (enc_unused_sb),
        .db_o   (enc_unused_db)
    );

    miv_secded_codec #(.WIDTH(WIDTH), .CW(CW)) u_dec (
        .data_i ('0),
        .cw_o   (dec_unused_cw),
        .cw_i   (mem_q[rd_addr]),
        .data_o (dec_data),
        .sb_o   (dec_sb),
        .db_o   (dec_db)
    );

    always_comb begin
        inj_mask = '0;
        if (WEN) begin
            case (inj_e'(INJ_ERR))
                INJ_SB:  inj_mask[0]   = 1'b1;
                INJ_DB:  inj_mask[1:0] = 2'b11;
                default: inj_mask      = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (WEN || wb_fire) mem_q[wr_addr] <= wr_cw ^ inj_mask;
        if (scr_rd) begin
            scr_data_q <= dec_data;
            scr_sb_q   <= dec_sb;
            scr_db_q   <= dec_db;
        end
    end

    // Scrub results are counted in CHECK even if SCRUB_EN drops on that same cycle.
    assign scr_sb_hit = (state_q == SCR_CHECK) && scr_sb_q;
    assign scr_db_hit = (state_q == SCR_CHECK) && scr_db_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        icnt_d  = icnt_q;
        scr_rd  = 1'b0;
        wb_fire = 1'b0;
        if (!SCRUB_EN) begin
            state_d = SCR_IDLE;
            icnt_d  = '0;
        end else begin
            case (state_q)
                SCR_IDLE: state_d = SCR_WAIT;
                SCR_WAIT: begin
                    if (!REN) begin
                        if (icnt_q == IW'(SCRUB_INTERVAL - 1)) begin
                            icnt_d  = '0;
                            state_d = SCR_READ;
                        end else begin
                            icnt_d = icnt_q + IW'(1);
                        end
                    end
                end
                SCR_READ: begin
                    if (!REN) begin
                        scr_rd  = 1'b1;
                        state_d = SCR_CHECK;
                    end
                end
                SCR_CHECK: begin
                    if (scr_sb_q) begin
                        state_d = SCR_WBACK;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = SCR_WAIT;
                    end
                end
                SCR_WBACK: begin
                    // A user write to the same word is newer than the scrubbed copy.
                    if (WEN && (WADDR == ptr_q)) begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = SCR_WAIT;
                    end else if (!WEN) begin
                        wb_fire = 1'b1;
                        ptr_d   = ptr_q + AW'(1);
                        state_d = SCR_WAIT;
                    end
                end
                default: state_d = SCR_IDLE;
            endcase
        end
    end

    assign usr_sb = REN & dec_sb;
    assign usr_db = REN & dec_db;

    always_comb begin
        sb_cnt_d   = sat_add(sb_cnt_q, {1'b0, usr_sb} + {1'b0, scr_sb_hit});
        db_cnt_d   = sat_add(db_cnt_q, {1'b0, usr_db} + {1'b0, scr_db_hit});
        err_addr_d = err_addr_q;
        err_vld_d  = err_vld_q;
        if (CNT_CLR) begin
            sb_cnt_d  = '0;
            db_cnt_d  = '0;
            err_vld_d = 1'b0;
        end else if (!err_vld_q) begin
            if (usr_sb || usr_db) begin
                err_addr_d = RADDR;
                err_vld_d  = 1'b1;
            end else if (scr_sb_hit || scr_db_hit) begin
                err_addr_d = ptr_q;
                err_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= SCR_IDLE;
            ptr_q      <= '0;
            icnt_q     <= '0;
            rd_p1_q    <= '0;
            vld_p1_q   <= 1'b0;
            sb_p1_q    <= 1'b0;
            db_p1_q    <= 1'b0;
            sb_cnt_q   <= '0;
            db_cnt_q   <= '0;
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            icnt_q     <= icnt_d;
            vld_p1_q   <= REN;
            sb_p1_q    <= usr_sb;
            db_p1_q    <= usr_db;
            if (REN) rd_p1_q <= dec_data;
            sb_cnt_q   <= sb_cnt_d;
            db_cnt_q   <= db_cnt_d;
            err_addr_q <= err_addr_d;
            err_vld_q  <= err_vld_d;
        end
    end

    assign RD         = rd_p1_q;
    assign RD_VALID   = vld_p1_q;
    assign SB_CORRECT = sb_p1_q;
    assign DB_DETECT  = db_p1_q;
    assign SB_COUNT   = sb_cnt_q;
    assign DB_COUNT   = db_cnt_q;
    assign ERR_ADDR   = err_addr_q;
    assign ERR_VALID  = err_vld_q;

endmodule

// File: doc/miv_ram_ecc_scrub.md
# miv_ram_ecc_scrub

Parametrised 1R1W SECDED-protected RAM for the MiV RV32 L1 memory subsystem. It generalises the fixed 2048x32 ECC RAM to any width and depth, and adds four things:
- registered error flags;
- saturating error counters with first-error address capture;
- error injection for test;
- a background scrubber that reads idle locations and writes back corrected data.

It sits between the AHB-facing TCM/cache controller and the storage array.

## Interface
- WIDTH, 32: data word width (8..64).
- DEPTH, 2048: number of words (power of two, ≥16).
- AW, $clog2(DEPTH): address width (derived).
- CW, secded_cw(WIDTH): check-bit count, Hamming bits plus overall parity; 7 for WIDTH=32.
- SCRUB_INTERVAL, 1024: idle cycles between scrub attempts (≥1).
- CNT_W, 16: error counter width.

Ports (all are synchronous to CLK):
- CLK  in  1  sole clock; all state is on the rising edge.
- RESETN  in  1  asynchronous assert, active-low reset.
- WEN  in  1  user write strobe.
- WADDR  in  AW  write address.
- WD  in  WIDTH  write data.
- REN  in  1  user read strobe.
- RADDR  in  AW  read address.
- RD  out  WIDTH  corrected read data.
- RD_VALID  out  1  RD and flags are valid this cycle.
- SB_CORRECT  out  1  single-bit error corrected on this read.
- DB_DETECT  out  1  uncorrectable double-bit error on this read.
- SCRUB_EN  in  1  enables the background scrubber.
- INJ_ERR  in  2  on the write: 01 flips codeword bit 0; 10 flips bits 0 and 1; 00/11 none.
- SB_COUNT  out  CNT_W  saturating single-bit error count (user reads and scrub reads).
- DB_COUNT  out  CNT_W  saturating double-bit error count.
- ERR_ADDR  out  AW  address of the first error since reset or clear.
- ERR_VALID  out  1  ERR_ADDR holds a captured address.
- CNT_CLR  in  1  synchronous clear of the counters and ERR_VALID.

## Operation
- **Storage:** DEPTH x (WIDTH+CW) codewords. The encoder is applied on every write. INJ_ERR is XORed into the codeword before it is stored.
- **User read:** RADDR is registered when REN=1. The array output is decoded, then registered to RD, SB_CORRECT, DB_DETECT and RD_VALID.
  - On DB_DETECT, RD carries the raw data bits uncorrected.
  - Flags are 0 whenever RD_VALID=0.
- **Read during write to the same address:** the read returns the old data (read-first).
- **Scrubber FSM, states IDLE, WAIT, READ, CHECK, WBACK:**
  - IDLE: go to WAIT when SCRUB_EN=1.
  - WAIT: an interval counter counts cycles with REN=0. When it reaches SCRUB_INTERVAL-1, go to READ.
  - READ: issues an internal read of scrub_ptr on a cycle with REN=0. A user read always wins; READ holds until the port is free.
  - CHECK: the decoder result is evaluated.
    - No error: scrub_ptr++ (wraps DEPTH-1→0), go to WAIT.
    - Single-bit error: latch the corrected word, go to WBACK.
    - Double-bit error: count it, scrub_ptr++, go to WAIT. No write-back.
  - WBACK: writes the re-encoded word to scrub_ptr on a cycle with WEN=0, then scrub_ptr++ and go to WAIT.
    - If a user write to scrub_ptr occurs while in WBACK, the write-back is dropped, because the user data is newer. scrub_ptr++ and go to WAIT.
  - SCRUB_EN deasserted in any state returns the FSM to IDLE at the next edge. scrub_ptr is retained.
- **Counters:**
  - Each counter increments once per flagged decode (user or scrub) and saturates at all-ones.
  - ERR_ADDR is captured only while ERR_VALID=0.
  - If a user decode and a scrub decode flag errors in the same cycle, the count is +1 per source. The user address has priority for ERR_ADDR.
  - CNT_CLR wins over a simultaneous increment: the result is 0.

## Timing
- **Read latency:** RD and RD_VALID are valid exactly 1 cycle after REN/RADDR are sampled. The decode is combinational on the array output, registered once.
- **Write:** the write takes effect at the sampling edge. A read of that address issued in the next cycle returns the new data.
- **Scrub cost:** a scrub never stalls the user ports. There is no back-pressure and no busy signal.
- **Reset:** RESETN low asynchronously clears the following to 0:
  - RD, RD_VALID, SB_CORRECT, DB_DETECT;
  - SB_COUNT, DB_COUNT, ERR_ADDR, ERR_VALID;
  - scrub_ptr and the interval counter;
  - the FSM, which goes to IDLE.

  Array contents are not reset. A reset in the middle of WBACK abandons the write-back.

## Structure
- **Package miv_ram_ecc_pkg:**
  - function secded_cw(width);
  - scrub state enum;
  - INJ_ERR encodings.
- **Sub-module miv_secded_codec:** purely combinational, parameterised by WIDTH.
  - Encoder: data → codeword.
  - Decoder: codeword → corrected data, sb, db.
  - It is instanced twice: once for encode and once for decode. The scrubber shares the read decoder.

## Test plan
- **Clean data:** write 0xDEADBEEF at 0x005, read 0x005 → RD=0xDEADBEEF one cycle later, SB=DB=0, counts 0.
- **Single-bit error:** write 0x12345678 at 0x7FF with INJ_ERR=01, read → RD=0x12345678, SB_CORRECT=1, SB_COUNT=1, ERR_ADDR=0x7FF, ERR_VALID=1.
- **Double-bit error:** write with INJ_ERR=10 at 0x010, read → DB_DETECT=1, DB_COUNT=1, SB_CORRECT=0.
- **Scrub write-back:** SCRUB_INTERVAL=4, SCRUB_EN=1, single-bit error at 0x000, no user traffic.
  - The scrub corrects the location and SB_COUNT=1.
  - A later user read of 0x000 → SB_CORRECT=0.
- **Write-back collision:** force the FSM into WBACK for 0x003 and issue a user write of 0xA5A5A5A5 to 0x003 in the same cycle → a readback gives 0xA5A5A5A5.
- **Saturation and reset:** with CNT_W=2, four single-bit reads → SB_COUNT=3. CNT_CLR with a simultaneous error → 0. RESETN pulsed mid-scrub → all outputs 0 and the FSM in IDLE.
